npu_sigmoid_fifo: RTL and testbench

Buffers 16-bit activations from the NPU sigmoid unit and feeds them back to the PEs as inputs to the next neuron layer. Sits directly downstream of the sigmoid unit. Every PE in the next layer consumes the same activation vector, so the FIFO supports replay:
- the scheduler can rewind the read pointer to a committed mark and re-stream the same entries;
- entries are freed only on commit.

---
 rtl/npu_sigmoid_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_npu_sigmoid_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_sigmoid_fifo.sv
// ---------------------------------------------------------------------------
// npu_sigmoid_fifo
//
// Activation buffer between the NPU sigmoid unit and the PE array. Entries
// are written by the sigmoid unit and streamed back out to the PEs. Every PE
// of the next layer consumes the same activation vector, so the read side can
// be replayed:
//   - commit records the current read position as the mark and releases every
//     entry before it;
//   - rewind moves the read position back to the mark and re-streams from
//     there.
// Space is reclaimed only on commit. This means full is measured from the
// mark and not from the read pointer.
//
// Ports
//   CLK                            clock, rising edge
//   npu_rst_n                      asynchronous reset, active low
//   npu_sigmoid_fifo_flush         synchronous clear of pointers, dout and flags
//   npu_sigmoid_fifo_din           write data from the sigmoid unit
//   npu_sched_sigmoid_fifo_wr_en   write request
//   npu_sched_sigmoid_fifo_rd_en   read request
//   npu_sched_sigmoid_fifo_commit  mark := rd_ptr (frees consumed entries)
//   npu_sched_sigmoid_fifo_rewind  rd_ptr := mark (replay)
//   npu_sigmoid_fifo_dout          registered read data
//   npu_sigmoid_fifo_dout_valid    dout was loaded at the last edge
//   npu_sigmoid_fifo_full          no free entry (wr_ptr - mark == DEPTH)
//   npu_sigmoid_fifo_empty         no unread entry (rd_ptr == wr_ptr)
//   npu_sigmoid_fifo_count         unread entries (wr_ptr - rd_ptr)
//   npu_sigmoid_fifo_overflow      sticky, a write was dropped
//   npu_sigmoid_fifo_underflow     sticky, a read was ignored
// ---------------------------------------------------------------------------
module npu_sigmoid_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              npu_rst_n,
    input  logic              npu_sigmoid_fifo_flush,
    input  logic [DATA_W-1:0] npu_sigmoid_fifo_din,
    input  logic              npu_sched_sigmoid_fifo_wr_en,
    input  logic              npu_sched_sigmoid_fifo_rd_en,
    input  logic              npu_sched_sigmoid_fifo_commit,
    input  logic              npu_sched_sigmoid_fifo_rewind,
    output logic [DATA_W-1:0] npu_sigmoid_fifo_dout,
    output logic              npu_sigmoid_fifo_dout_valid,
    output logic              npu_sigmoid_fifo_full,
    output logic              npu_sigmoid_fifo_empty,
    output logic [ADDR_W:0]   npu_sigmoid_fifo_count,
    output logic              npu_sigmoid_fifo_overflow,
    output logic              npu_sigmoid_fifo_underflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty are distinct
    // when the low address bits coincide.
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  mark_ptr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [PTR_W-1:0]  used_from_mark;

    logic              wr_accept;
    logic              wr_drop;
    logic              rd_accept;
    logic              rd_reject;
    logic              commit_take;

    // -----------------------------------------------------------------------
    // Status, all derived from registered pointers.
    // -----------------------------------------------------------------------
    assign wr_addr        = wr_ptr[ADDR_W-1:0];
    assign rd_addr        = rd_ptr[ADDR_W-1:0];
    assign used_from_mark = wr_ptr - mark_ptr;

    assign npu_sigmoid_fifo_empty = (rd_ptr == wr_ptr);
    assign npu_sigmoid_fifo_full  = (used_from_mark == PTR_DEPTH);
    assign npu_sigmoid_fifo_count = wr_ptr - rd_ptr;

    // -----------------------------------------------------------------------
    // Request qualification. Flush wins over everything. Rewind suppresses
    // the read and the commit of the same cycle without raising a flag. All
    // decisions use the pre-edge flags, so a same-cycle read never makes room
    // for a write and a same-cycle write never feeds a read.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_accept   = 1'b0;
        wr_drop     = 1'b0;
        rd_accept   = 1'b0;
        rd_reject   = 1'b0;
        commit_take = 1'b0;
        if (!npu_sigmoid_fifo_flush) begin
            if (npu_sched_sigmoid_fifo_wr_en) begin
                wr_accept = !npu_sigmoid_fifo_full;
                wr_drop   =  npu_sigmoid_fifo_full;
            end
            if (!npu_sched_sigmoid_fifo_rewind) begin
                if (npu_sched_sigmoid_fifo_rd_en) begin
                    rd_accept = !npu_sigmoid_fifo_empty;
                    rd_reject =  npu_sigmoid_fifo_empty;
                end
                commit_take = npu_sched_sigmoid_fifo_commit;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage. It is not reset; only the pointers decide which entries are
    // meaningful.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_addr] <= npu_sigmoid_fifo_din;
        end
    end

    // -----------------------------------------------------------------------
    // Write pointer.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            wr_ptr <= '0;
        end else if (npu_sigmoid_fifo_flush) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Read pointer. Rewind moves it back to the mark. Otherwise an accepted
    // read advances it.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            rd_ptr <= '0;
        end else if (npu_sigmoid_fifo_flush) begin
            rd_ptr <= '0;
        end else if (npu_sched_sigmoid_fifo_rewind) begin
            rd_ptr <= mark_ptr;
        end else if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Mark pointer. It takes the pre-edge read pointer, so an entry that is
    // read in the commit cycle stays allocated until the next commit.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            mark_ptr <= '0;
        end else if (npu_sigmoid_fifo_flush) begin
            mark_ptr <= '0;
        end else if (commit_take) begin
            mark_ptr <= rd_ptr;
        end
    end

    // -----------------------------------------------------------------------
    // Read data. dout holds its value whenever no read is accepted.
    // dout_valid only marks the edges that loaded dout.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            npu_sigmoid_fifo_dout       <= '0;
            npu_sigmoid_fifo_dout_valid <= 1'b0;
        end else if (npu_sigmoid_fifo_flush) begin
            npu_sigmoid_fifo_dout       <= '0;
            npu_sigmoid_fifo_dout_valid <= 1'b0;
        end else begin
            npu_sigmoid_fifo_dout_valid <= rd_accept;
            if (rd_accept) begin
                npu_sigmoid_fifo_dout <= mem[rd_addr];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sticky error flags. Only reset or flush clears them.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            npu_sigmoid_fifo_overflow  <= 1'b0;
            npu_sigmoid_fifo_underflow <= 1'b0;
        end else if (npu_sigmoid_fifo_flush) begin
            npu_sigmoid_fifo_overflow  <= 1'b0;
            npu_sigmoid_fifo_underflow <= 1'b0;
        end else begin
            if (wr_drop) begin
                npu_sigmoid_fifo_overflow <= 1'b1;
            end
            if (rd_reject) begin
                npu_sigmoid_fifo_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_npu_sigmoid_fifo.sv
module tb_npu_sigmoid_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              CLK = 1'b0;
    logic              npu_rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              commit = 1'b0;
    logic              rewind = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    npu_sigmoid_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK                           (CLK),
        .npu_rst_n                     (npu_rst_n),
        .npu_sigmoid_fifo_flush        (flush),
        .npu_sigmoid_fifo_din          (din),
        .npu_sched_sigmoid_fifo_wr_en  (wr_en),
        .npu_sched_sigmoid_fifo_rd_en  (rd_en),
        .npu_sched_sigmoid_fifo_commit (commit),
        .npu_sched_sigmoid_fifo_rewind (rewind),
        .npu_sigmoid_fifo_dout         (dout),
        .npu_sigmoid_fifo_dout_valid   (dout_valid),
        .npu_sigmoid_fifo_full         (full),
        .npu_sigmoid_fifo_empty        (empty),
        .npu_sigmoid_fifo_count        (count),
        .npu_sigmoid_fifo_overflow     (overflow),
        .npu_sigmoid_fifo_underflow    (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid output word must match the oldest expected word.
    initial begin
        forever begin
            @(negedge CLK);
            if (dout_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL dout_unexpected: got 0x%0h expected no valid word", dout);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        n_err++;
                        $display("FAIL dout: got 0x%0h expected 0x%0h", dout, e);
                    end
                end
            end
        end
    end

    // One clock cycle with the given request set. Inputs go back to idle at #1
    // after the edge.
    task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic r,
                       input logic cm, input logic rw, input logic fl);
        wr_en = w; din = d; rd_en = r; commit = cm; rewind = rw; flush = fl;
        @(posedge CLK);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; commit = 1'b0; rewind = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        @(negedge CLK);
        npu_rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // 1: basic order
        wr(16'h0001);
        chk("t1_empty_after_wr", empty, 0);
        chk("t1_count1", count, 1);
        wr(16'h0002); wr(16'h0003); wr(16'h0004);
        chk("t1_count4", count, 4);
        for (int i = 1; i <= 4; i++) rd(DATA_W'(i));
        @(negedge CLK);
        chk("t1_count0", count, 0);
        chk("t1_empty", empty, 1);
        chk("t1_ovf", overflow, 0);
        chk("t1_udf", underflow, 0);
        do_flush();

        // 2: fill and overflow
        for (int i = 0; i < 15; i++) wr(DATA_W'(i));
        chk("t2_full_at15", full, 0);
        wr(16'd15);
        chk("t2_full_at16", full, 1);
        chk("t2_count16", count, 16);
        chk("t2_ovf_before", overflow, 0);
        wr(16'hDEAD);
        chk("t2_ovf", overflow, 1);
        chk("t2_count_still16", count, 16);
        for (int i = 0; i < 16; i++) rd(DATA_W'(i));
        chk("t2_count_drained", count, 0);
        chk("t2_full_no_commit", full, 1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_count_rewind", count, 16);
        for (int i = 0; i < 16; i++) rd(DATA_W'(i));
        @(negedge CLK);
        do_flush();
        chk("t2_ovf_flushed", overflow, 0);

        // 3: replay
        wr(16'hA0A0); wr(16'hB0B0); wr(16'hC0C0);
        rd(16'hA0A0); rd(16'hB0B0); rd(16'hC0C0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_count_rewind", count, 3);
        rd(16'hA0A0); rd(16'hB0B0); rd(16'hC0C0);
        chk("t3_full", full, 0);
        @(negedge CLK);
        do_flush();

        // 4: commit frees space
        for (int i = 0; i < 16; i++) wr(DATA_W'(16'h0100 + i));
        for (int i = 0; i < 4; i++) rd(DATA_W'(16'h0100 + i));
        chk("t4_full_before_commit", full, 1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_full_after_commit", full, 0);
        for (int i = 0; i < 4; i++) wr(DATA_W'(16'h0200 + i));
        chk("t4_ovf", overflow, 0);
        chk("t4_full_again", full, 1);
        chk("t4_count", count, 16);
        rd(16'h0104); rd(16'h0105);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        rd(16'h0104);
        @(negedge CLK);
        do_flush();

        // 5: underflow and simultaneous events
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_udf", underflow, 1);
        chk("t5_udf_valid", dout_valid, 0);
        chk("t5_udf_dout_hold", dout, 0);
        cyc(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_wr_rd_count", count, 1);
        chk("t5_wr_rd_valid", dout_valid, 0);
        rd(16'h5555);
        @(negedge CLK);
        do_flush();
        wr(16'h7777);
        rd(16'h7777);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_rw_rd_valid", dout_valid, 0);
        chk("t5_rw_rd_count", count, 1);
        chk("t5_rw_rd_udf", underflow, 0);
        chk("t5_rw_rd_dout_hold", dout, 16'h7777);
        rd(16'h7777);
        @(negedge CLK);
        do_flush();

        // 6: flush and async reset mid-operation
        for (int i = 0; i < 17; i++) wr(DATA_W'(16'h0300 + i));
        for (int i = 0; i < 11; i++) rd(DATA_W'(16'h0300 + i));
        chk("t6_count5", count, 5);
        chk("t6_ovf_set", overflow, 1);
        @(negedge CLK);
        do_flush();
        chk("t6_fl_count", count, 0);
        chk("t6_fl_empty", empty, 1);
        chk("t6_fl_ovf", overflow, 0);
        chk("t6_fl_udf", underflow, 0);
        chk("t6_fl_dout", dout, 0);
        wr(16'h0AAA); wr(16'h0BBB);
        rd(16'h0AAA);
        @(negedge CLK);
        #1;
        npu_rst_n = 1'b0;
        #1;
        chk("t6_ar_dout", dout, 0);
        chk("t6_ar_valid", dout_valid, 0);
        chk("t6_ar_count", count, 0);
        chk("t6_ar_empty", empty, 1);
        chk("t6_ar_full", full, 0);
        @(negedge CLK);
        npu_rst_n = 1'b1;
        @(posedge CLK);
        #1;

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
